// File: rtl/regbank_sequencer_if.sv
// Command and register-bank bus for regbank_sequencer.
//   cmd_*     : one-at-a-time command handshake from the instruction decoder
//   busy/done : sequencer status, done pulses for one cycle per finished command
//   result    : value last written to the destination, held until the next done
//   bank_*    : single-port register-bank access (combinational reads, posedge writes)
// The master modport is the sequencer; the slave modport is the decoder/bank side.
interface regbank_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_src;
  logic [2:0]  cmd_dst;
  logic [15:0] cmd_imm;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  bank_regNum;
  logic [7:0]  bank_dataIn;
  logic        bank_writeEnable;
  logic [15:0] bank_dataIn16;
  logic        bank_writeEnable16;
  logic [7:0]  bank_dataOut;
  logic [15:0] bank_dataOut16;

  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bank_dataOut, bank_dataOut16,
    output cmd_ready, busy, done, result,
           bank_regNum, bank_dataIn, bank_writeEnable, bank_dataIn16, bank_writeEnable16
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bank_dataOut, bank_dataOut16,
    input  cmd_ready, busy, done, result,
           bank_regNum, bank_dataIn, bank_writeEnable, bank_dataIn16, bank_writeEnable16
  );
endinterface

// File: rtl/regbank_sequencer.sv
// Command-driven initiator for the CPU register bank (B C D E H L W Z = 0..7).
// Runs one register-transfer command at a time as read phases followed by write
// phases over the bank's single port.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : synchronous, active-high; aborts any command in the cycle it is high
//   bus   : regbank_sequencer_if.master (command handshake, status, bank access)
// Parameter STEP: amount added by INC16 / subtracted by DEC16, modulo 2^16.
module regbank_sequencer #(
  parameter logic [15:0] STEP = 16'd1
) (
  input  logic                        clk,
  input  logic                        reset,
  regbank_sequencer_if.master         bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_A, ST_RD_B, ST_WR_A, ST_WR_B, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP, OP_MOV8, OP_LDI8, OP_LDI16, OP_INC16, OP_DEC16, OP_MOV16, OP_SWAP16
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [2:0]  src_q, src_d, dst_q, dst_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  regnum_q, regnum_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        we_q, we_d;
  logic [15:0] data_in16_q, data_in16_d;
  logic        we16_q, we16_d;
  logic        done_q, done_d;
  logic [15:0] wr_val;
  logic        op8;

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    imm_d       = imm_q;
    tmp_a_d     = tmp_a_q;
    tmp_b_d     = tmp_b_q;
    result_d    = result_q;
    regnum_d    = '0;
    data_in_d   = '0;
    we_d        = 1'b0;
    data_in16_d = '0;
    we16_d      = 1'b0;
    done_d      = 1'b0;
    wr_val      = '0;
    op8         = 1'b0;

    // Next-state and operand capture.
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = op_e'(bus.cmd_op);
          src_d = bus.cmd_src;
          dst_d = bus.cmd_dst;
          imm_d = bus.cmd_imm;
          case (op_e'(bus.cmd_op))
            OP_NOP:            state_d = ST_DONE;
            OP_LDI8, OP_LDI16: state_d = ST_WR_A;
            default:           state_d = ST_RD_A;
          endcase
        end
      end
      ST_RD_A: begin
        // MOV8 is the only 8-bit op that reads; everything else reads a pair.
        tmp_a_d = (op_q == OP_MOV8) ? {8'h00, bus.bank_dataOut} : bus.bank_dataOut16;
        state_d = (op_q == OP_SWAP16) ? ST_RD_B : ST_WR_A;
      end
      ST_RD_B: begin
        tmp_b_d = bus.bank_dataOut16;
        state_d = ST_WR_A;
      end
      ST_WR_A: state_d = (op_q == OP_SWAP16) ? ST_WR_B : ST_DONE;
      ST_WR_B: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Value written in WR_A; built from the *_d copies so it is ready the
    // cycle WR_A is entered (LDI skips the read phases).
    op8 = (op_d == OP_MOV8) || (op_d == OP_LDI8);
    case (op_d)
      OP_LDI8:  wr_val = {8'h00, imm_d[7:0]};
      OP_LDI16: wr_val = imm_d;
      OP_INC16: wr_val = tmp_a_d + STEP;
      OP_DEC16: wr_val = tmp_a_d - STEP;
      OP_MOV8, OP_MOV16, OP_SWAP16: wr_val = tmp_a_d;
      default:  wr_val = '0;
    endcase

    // Bank outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      ST_RD_A: regnum_d = src_d;
      ST_RD_B: regnum_d = dst_d;
      ST_WR_A: begin
        regnum_d = (op_d == OP_INC16 || op_d == OP_DEC16) ? src_d : dst_d;
        if (op8) begin
          we_d      = 1'b1;
          data_in_d = wr_val[7:0];
        end else begin
          we16_d      = 1'b1;
          data_in16_d = wr_val;
        end
      end
      ST_WR_B: begin
        regnum_d    = src_d;
        we16_d      = 1'b1;
        data_in16_d = tmp_b_d;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase

    // result tracks the destination write (WR_A); a NOP leaves it untouched.
    if (state_d == ST_DONE && (state_q == ST_WR_A || state_q == ST_WR_B)) begin
      result_d = wr_val;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      src_q       <= '0;
      dst_q       <= '0;
      imm_q       <= '0;
      tmp_a_q     <= '0;
      tmp_b_q     <= '0;
      result_q    <= '0;
      regnum_q    <= '0;
      data_in_q   <= '0;
      we_q        <= 1'b0;
      data_in16_q <= '0;
      we16_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      imm_q       <= imm_d;
      tmp_a_q     <= tmp_a_d;
      tmp_b_q     <= tmp_b_d;
      result_q    <= result_d;
      regnum_q    <= regnum_d;
      data_in_q   <= data_in_d;
      we_q        <= we_d;
      data_in16_q <= data_in16_d;
      we16_q      <= we16_d;
      done_q      <= done_d;
    end
  end

  // Reset masks the registered outputs in the reset cycle itself, so an
  // aborted command can never commit a write on the reset edge.
  assign bus.cmd_ready          = (state_q == ST_IDLE) && !reset;
  assign bus.busy               = (state_q != ST_IDLE) && !reset;
  assign bus.done               = done_q && !reset;
  assign bus.result             = result_q;
  assign bus.bank_regNum        = reset ? 3'd0  : regnum_q;
  assign bus.bank_dataIn        = reset ? 8'd0  : data_in_q;
  assign bus.bank_writeEnable   = we_q && !reset;
  assign bus.bank_dataIn16      = reset ? 16'd0 : data_in16_q;
  assign bus.bank_writeEnable16 = we16_q && !reset;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Scoreboard bench for regbank_sequencer: a behavioural register-bank model
// answers the DUT's bank port, a command-level reference model predicts the
// register file, result and latency of each accepted command, and a monitor
// compares whenever done pulses.
module tb_regbank_sequencer;

  localparam logic [15:0] STEP = 16'd1;
  localparam logic [2:0] NOP = 3'd0, MOV8 = 3'd1, LDI8 = 3'd2, LDI16 = 3'd3,
                         INC16 = 3'd4, DEC16 = 3'd5, MOV16 = 3'd6, SWAP16 = 3'd7;

  logic clk;
  logic reset;
  logic bank_clr;
  int   cyc;
  int   errors;
  int   checks;
  int   we16_cnt;

  regbank_sequencer_if bus ();

  regbank_sequencer #(.STEP(STEP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register bank model ----------------
  logic [7:0] bank [8];

  always_comb begin
    bus.bank_dataOut   = bank[bus.bank_regNum];
    bus.bank_dataOut16 = {bank[{bus.bank_regNum[2:1], 1'b0}], bank[{bus.bank_regNum[2:1], 1'b1}]};
  end

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
    end else begin
      if (bus.bank_writeEnable) bank[bus.bank_regNum] <= bus.bank_dataIn;
      if (bus.bank_writeEnable16) begin
        bank[{bus.bank_regNum[2:1], 1'b0}] <= bus.bank_dataIn16[15:8];
        bank[{bus.bank_regNum[2:1], 1'b1}] <= bus.bank_dataIn16[7:0];
      end
    end
  end

  function automatic logic [63:0] pack_bank();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63 - 8*i -: 8] = bank[i];
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  gold [8];
  logic [15:0] model_result;

  function automatic logic [63:0] pack_gold();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63 - 8*i -: 8] = gold[i];
    return r;
  endfunction

  function automatic logic [15:0] get_pair(input logic [1:0] p);
    return {gold[{p, 1'b0}], gold[{p, 1'b1}]};
  endfunction

  function automatic void set_pair(input logic [1:0] p, input logic [15:0] v);
    gold[{p, 1'b0}] = v[15:8];
    gold[{p, 1'b1}] = v[7:0];
  endfunction

  // Applies one command to the golden register file; returns result and latency.
  function automatic void model_exec(input logic [2:0] op, input logic [2:0] src,
                                     input logic [2:0] dst, input logic [15:0] imm,
                                     output logic [15:0] res, output int lat);
    logic [15:0] a, b;
    case (op)
      NOP:    lat = 1;
      MOV8:   begin gold[dst] = gold[src]; model_result = {8'h00, gold[dst]}; lat = 3; end
      LDI8:   begin gold[dst] = imm[7:0]; model_result = {8'h00, imm[7:0]}; lat = 2; end
      LDI16:  begin set_pair(dst[2:1], imm); model_result = imm; lat = 2; end
      INC16:  begin a = get_pair(src[2:1]) + STEP; set_pair(src[2:1], a); model_result = a; lat = 3; end
      DEC16:  begin a = get_pair(src[2:1]) - STEP; set_pair(src[2:1], a); model_result = a; lat = 3; end
      MOV16:  begin a = get_pair(src[2:1]); set_pair(dst[2:1], a); model_result = a; lat = 3; end
      default: begin
        a = get_pair(src[2:1]);
        b = get_pair(dst[2:1]);
        set_pair(dst[2:1], a);
        set_pair(src[2:1], b);
        model_result = a;
        lat = 5;
      end
    endcase
    res = model_result;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] result;
    int          done_cyc;
    logic [63:0] regs;
  } exp_t;

  exp_t sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("strobe_exclusive", 64'(bus.bank_writeEnable & bus.bank_writeEnable16), 0);
      if (!bus.bank_writeEnable)   check("data8_idle_zero", 64'(bus.bank_dataIn), 0);
      if (!bus.bank_writeEnable16) check("data16_idle_zero", 64'(bus.bank_dataIn16), 0);
      check("busy_vs_ready", 64'(bus.busy), 64'(!bus.cmd_ready));
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", 64'(bus.result), 64'(e.result));
          check("latency", 64'(cyc), 64'(e.done_cyc));
          check("regs", pack_bank(), e.regs);
        end
      end
    end
    if (bus.bank_writeEnable16) we16_cnt <= we16_cnt + 1;
  end

  // ---------------- driver ----------------
  // Entered and left at a falling edge. With hold=1 cmd_valid stays high with
  // junk fields for the whole busy window; none of it may be executed.
  task automatic issue(input logic [2:0] op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [15:0] imm, input bit hold);
    int n;
    exp_t e;
    logic [15:0] res;
    int lat;
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_imm   = imm;
    model_exec(op, src, dst, imm, res, lat);
    e.result   = res;
    e.done_cyc = cyc + lat;
    e.regs     = pack_gold();
    sb.push_back(e);
    @(negedge clk);
    n = 0;
    while (n < 10) begin
      check("ready_low_while_busy", 64'(bus.cmd_ready), 0);
      if (bus.done) break;
      if (hold) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_src   = 3'($urandom);
        bus.cmd_dst   = 3'($urandom);
        bus.cmd_imm   = 16'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt0;
    logic [15:0] old_bc;

    errors = 0;
    checks = 0;
    cyc = 0;
    we16_cnt = 0;
    model_result = 16'h0000;
    for (int i = 0; i < 8; i++) gold[i] = 8'h00;
    reset = 1'b1;
    bank_clr = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_src = '0;
    bus.cmd_dst = '0;
    bus.cmd_imm = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.cmd_ready), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_result", 64'(bus.result), 0);
    check("rst_bank_out", 64'({bus.bank_regNum, bus.bank_writeEnable, bus.bank_writeEnable16,
                                bus.bank_dataIn, bus.bank_dataIn16}), 0);
    #2 reset = 1'b0;
    bank_clr = 1'b0;
    #1 check("ready_after_reset", 64'(bus.cmd_ready), 1);
    @(negedge clk);

    // LDI16 then MOV8 (D=0x12, E=0x34, Z=0x12).
    issue(LDI16, 3'd0, 3'd2, 16'h1234, 1'b0);
    issue(MOV8, 3'd2, 3'd7, 16'h0000, 1'b0);
    check("z_reg", 64'(bank[7]), 64'h12);
    // INC16 wrap and DEC16 wrap on HL.
    issue(LDI16, 3'd0, 3'd4, 16'hFFFF, 1'b0);
    issue(INC16, 3'd4, 3'd0, 16'h0000, 1'b0);
    issue(DEC16, 3'd5, 3'd0, 16'h0000, 1'b0);
    // SWAP16 of BC and DE, two 16-bit strobes.
    issue(LDI16, 3'd0, 3'd0, 16'hAABB, 1'b0);
    issue(LDI16, 3'd0, 3'd2, 16'hCCDD, 1'b0);
    cnt0 = we16_cnt;
    issue(SWAP16, 3'd0, 3'd2, 16'h0000, 1'b0);
    check("swap_we16_pulses", 64'(we16_cnt - cnt0), 2);
    // Same-pair SWAP16 and same-register MOV8.
    issue(LDI16, 3'd0, 3'd0, 16'h5678, 1'b0);
    issue(SWAP16, 3'd1, 3'd0, 16'h0000, 1'b0);
    issue(MOV8, 3'd3, 3'd3, 16'h0000, 1'b0);
    issue(LDI8, 3'd0, 3'd6, 16'hBE5A, 1'b0);
    issue(NOP, 3'd0, 3'd0, 16'h0000, 1'b0);
    // cmd_valid held high while busy.
    issue(MOV16, 3'd6, 3'd4, 16'h0000, 1'b1);
    issue(SWAP16, 3'd2, 3'd6, 16'h0000, 1'b1);

    // Reset in the WR_B cycle of SWAP16: only the WR_A write survives.
    issue(LDI16, 3'd0, 3'd0, 16'h1111, 1'b0);
    issue(LDI16, 3'd0, 3'd2, 16'h2222, 1'b0);
    n = 0;
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_abort", 64'(bus.cmd_ready), 1);
    old_bc = get_pair(2'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = SWAP16;
    bus.cmd_src   = 3'd0;
    bus.cmd_dst   = 3'd2;
    bus.cmd_imm   = 16'h0000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wrb_strobe_before_reset", 64'(bus.bank_writeEnable16), 1);
    set_pair(2'd1, old_bc);
    model_result = 16'h0000;
    #2 reset = 1'b1;
    #1 check("wrb_strobe_masked", 64'(bus.bank_writeEnable16), 0);
    check("abort_done_low", 64'(bus.done), 0);
    check("abort_ready_low", 64'(bus.cmd_ready), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("abort_ready_high", 64'(bus.cmd_ready), 1);
    check("abort_result", 64'(bus.result), 0);
    check("abort_regs", pack_bank(), pack_gold());
    @(negedge clk);

    // Randomized commands.
    for (int k = 0; k < 150; k++) begin
      issue(3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
